// File: rtl/cam_pixel_rx.sv
// DVP camera receiver: filters href/vsync, assembles 1- or 2-byte pixels, frames them with
// sof/eol and measures line/frame geometry with sticky error flags.
module cam_pixel_rx #(
  parameter int unsigned DATA_W        = 8,
  parameter int unsigned BYTES_PER_PIX = 1,
  parameter int unsigned PIX_PER_LINE  = 640,
  parameter int unsigned NUM_LINES     = 480,
  parameter int unsigned SYNC_FILT     = 3,
  parameter int unsigned CNT_W         = 16
) (
  input  logic                            pclk,
  input  logic                            rst,
  input  logic [DATA_W-1:0]               din,
  input  logic                            vsync,
  input  logic                            href,
  input  logic                            start,
  input  logic                            stop,
  output logic [DATA_W*BYTES_PER_PIX-1:0] pixel,
  output logic                            pixel_valid,
  output logic                            sof,
  output logic                            eol,
  output logic                            busy,
  output logic [CNT_W-1:0]                hlen,
  output logic [CNT_W-1:0]                vlen,
  output logic [CNT_W-1:0]                frame_cnt,
  output logic                            line_err,
  output logic                            frame_err
);
  localparam int unsigned PIX_W = DATA_W * BYTES_PER_PIX;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] PPL = CNT_W'(PIX_PER_LINE);
  localparam logic [CNT_W-1:0] NL = CNT_W'(NUM_LINES);
  localparam logic [2:0] FILT_N = 3'(SYNC_FILT);

  typedef enum logic [2:0] {StIdle, StWaitVs, StVblank, StHblank, StHact} state_e;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == CNT_MAX) ? v : v + CNT_W'(1);
  endfunction

  logic [DATA_W-1:0] din_r;
  logic              href_r, vs_r;
  logic [DATA_W-1:0] dly_q [SYNC_FILT+1];
  logic              hf_q, hf_d, vf_q, vf_d, hd_q, vd_q;
  logic [2:0]        hcnt_q, hcnt_d, vcnt_q, vcnt_d;

  // Delay line aligns the byte with the one-cycle-delayed filtered href (hd_q).
  always_ff @(posedge pclk or posedge rst) begin
    if (rst) begin
      din_r  <= '0;
      href_r <= 1'b0;
      vs_r   <= 1'b0;
      for (int unsigned i = 0; i <= SYNC_FILT; i++) dly_q[i] <= '0;
      hf_q   <= 1'b0;
      vf_q   <= 1'b0;
      hd_q   <= 1'b0;
      vd_q   <= 1'b0;
      hcnt_q <= '0;
      vcnt_q <= '0;
    end else begin
      din_r    <= din;
      href_r   <= href;
      vs_r     <= vsync;
      dly_q[0] <= din_r;
      for (int unsigned i = 1; i <= SYNC_FILT; i++) dly_q[i] <= dly_q[i-1];
      hf_q   <= hf_d;
      vf_q   <= vf_d;
      hd_q   <= hf_q;
      vd_q   <= vf_q;
      hcnt_q <= hcnt_d;
      vcnt_q <= vcnt_d;
    end
  end

  always_comb begin
    hf_d   = hf_q;
    hcnt_d = '0;
    vf_d   = vf_q;
    vcnt_d = '0;
    if (href_r != hf_q) begin
      if (hcnt_q + 3'd1 == FILT_N) hf_d = href_r;
      else hcnt_d = hcnt_q + 3'd1;
    end
    if (vs_r != vf_q) begin
      if (vcnt_q + 3'd1 == FILT_N) vf_d = vs_r;
      else vcnt_d = vcnt_q + 3'd1;
    end
  end

  // Qualified href for the current byte (act_d), the next byte (act) and the one after (act_n).
  logic act_d, act, act_n, vs_rise, vs_fall;
  assign act_d   = hd_q & ~vd_q;
  assign act     = hf_q & ~vf_q;
  assign act_n   = hf_d & ~vf_d;
  assign vs_rise = vf_q & ~vd_q;
  assign vs_fall = ~vf_q & vd_q;

  state_e            state_q, state_d;
  logic              stop_pend_q, stop_pend_d, sof_pend_q, phase_q;
  logic [CNT_W-1:0]  pix_cnt_q, line_cnt_q;
  logic              take, last_phase, cap, emit, eol_n, close, line_done;
  logic              frame_end, vb_entry;
  logic [CNT_W-1:0]  close_cnt, lines_fin;
  logic [PIX_W-1:0]  asm_pix;

  always_comb begin
    take       = (state_q == StHact) && act_d;
    last_phase = (BYTES_PER_PIX == 1) || phase_q;
    cap        = last_phase && (pix_cnt_q == PPL - CNT_W'(1));
    emit       = take && last_phase;
    if (BYTES_PER_PIX == 1) eol_n = emit && (cap || !act);
    else eol_n = emit && (cap || !act || !act_n);
    // A lone first byte at line end is dropped.
    close      = eol_n || (take && !last_phase && !act);
    close_cnt  = emit ? sat_inc(pix_cnt_q) : pix_cnt_q;
    line_done  = close && (close_cnt != '0);
    lines_fin  = line_done ? sat_inc(line_cnt_q) : line_cnt_q;

    state_d     = state_q;
    stop_pend_d = stop_pend_q;
    frame_end   = 1'b0;
    vb_entry    = 1'b0;
    if (start) stop_pend_d = 1'b0;
    if (stop && state_q != StIdle) stop_pend_d = 1'b1;
    unique case (state_q)
      StIdle:   if (start && !stop) state_d = StWaitVs;
      StWaitVs: begin
        if (stop) state_d = StIdle;
        else if (vs_rise) begin
          state_d  = StVblank;
          vb_entry = 1'b1;
        end
      end
      StVblank: if (vs_fall) state_d = StHblank;
      StHblank, StHact: begin
        if (vs_rise) begin
          frame_end = 1'b1;
          if (stop_pend_q || stop) state_d = StIdle;
          else begin
            state_d  = StVblank;
            vb_entry = 1'b1;
          end
        end else if (state_q == StHblank) begin
          if (act && !act_d) state_d = StHact;
        end else if (close) begin
          state_d = StHblank;
        end
      end
      default: state_d = StIdle;
    endcase
    if (state_d == StIdle) stop_pend_d = 1'b0;
  end

  if (BYTES_PER_PIX == 2) begin : g_two
    logic [DATA_W-1:0] msb_q;
    always_ff @(posedge pclk or posedge rst) begin
      if (rst) msb_q <= '0;
      else if (take && !phase_q) msb_q <= dly_q[SYNC_FILT];
    end
    assign asm_pix = {msb_q, dly_q[SYNC_FILT]};
  end else begin : g_one
    assign asm_pix = dly_q[SYNC_FILT];
  end

  always_ff @(posedge pclk or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      stop_pend_q <= 1'b0;
      sof_pend_q  <= 1'b0;
      phase_q     <= 1'b0;
      pix_cnt_q   <= '0;
      line_cnt_q  <= '0;
      pixel       <= '0;
      pixel_valid <= 1'b0;
      sof         <= 1'b0;
      eol         <= 1'b0;
      busy        <= 1'b0;
      hlen        <= '0;
      vlen        <= '0;
      frame_cnt   <= '0;
      line_err    <= 1'b0;
      frame_err   <= 1'b0;
    end else begin
      state_q     <= state_d;
      stop_pend_q <= stop_pend_d;
      busy        <= (state_d != StIdle);
      pixel_valid <= emit;
      eol         <= eol_n;
      sof         <= emit && sof_pend_q;
      if (emit) pixel <= asm_pix;

      if (vb_entry) sof_pend_q <= 1'b1;
      else if (emit) sof_pend_q <= 1'b0;

      if (state_q == StHblank && state_d == StHact) begin
        pix_cnt_q <= '0;
        phase_q   <= 1'b0;
      end else if (take) begin
        phase_q <= (BYTES_PER_PIX == 2) ? ~phase_q : 1'b0;
        if (emit) pix_cnt_q <= sat_inc(pix_cnt_q);
      end

      if (vb_entry) line_cnt_q <= '0;
      else if (line_done) line_cnt_q <= lines_fin;

      if (start) begin
        line_err  <= 1'b0;
        frame_err <= 1'b0;
      end
      if (state_q == StIdle && start && !stop) frame_cnt <= '0;
      if (line_done) begin
        hlen <= close_cnt;
        if (close_cnt != PPL) line_err <= 1'b1;
      end
      if (frame_end) begin
        vlen      <= lines_fin;
        frame_cnt <= frame_cnt + CNT_W'(1);
        if (lines_fin != NL) frame_err <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_cam_pixel_rx.sv
// Scoreboard bench for cam_pixel_rx with 2-byte pixels and a small frame geometry.
module tb_cam_pixel_rx;
  localparam int unsigned DW  = 8;
  localparam int unsigned BPP = 2;
  localparam int unsigned PPL = 4;
  localparam int unsigned NL  = 3;
  localparam int unsigned SF  = 3;
  localparam int unsigned CW  = 16;
  localparam int unsigned L   = SF + 2;

  logic              pclk = 1'b0;
  logic              rst = 1'b1;
  logic [DW-1:0]     din = '0;
  logic              vsync = 1'b0, href = 1'b0, start = 1'b0, stop = 1'b0;
  logic [DW*BPP-1:0] pixel;
  logic              pixel_valid, sof, eol, busy, line_err, frame_err;
  logic [CW-1:0]     hlen, vlen, frame_cnt;

  cam_pixel_rx #(
    .DATA_W(DW), .BYTES_PER_PIX(BPP), .PIX_PER_LINE(PPL), .NUM_LINES(NL),
    .SYNC_FILT(SF), .CNT_W(CW)
  ) u_dut (
    .pclk(pclk), .rst(rst), .din(din), .vsync(vsync), .href(href), .start(start), .stop(stop),
    .pixel(pixel), .pixel_valid(pixel_valid), .sof(sof), .eol(eol), .busy(busy),
    .hlen(hlen), .vlen(vlen), .frame_cnt(frame_cnt), .line_err(line_err),
    .frame_err(frame_err)
  );

  always #5 pclk = ~pclk;

  int unsigned cyc = 0;
  always @(posedge pclk) cyc <= cyc + 1;

  typedef struct {
    logic [15:0] pix;
    logic        sof;
    logic        eol;
    int unsigned cyc;
  } exp_t;

  exp_t q[$];
  int   n_cmp = 0;
  int   n_err = 0;
  bit   sof_exp = 1'b0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  always @(negedge pclk) begin
    exp_t e;
    if (!rst && pixel_valid) begin
      if (q.size() == 0) chk("unexpected_pixel", 64'(pixel_valid), 64'd0);
      else begin
        e = q.pop_front();
        chk("pixel", 64'(pixel), 64'(e.pix));
        chk("sof", 64'(sof), 64'(e.sof));
        chk("eol", 64'(eol), 64'(e.eol));
        chk("latency_cycle", 64'(cyc), 64'(e.cyc));
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge pclk);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick(1);
    start = 1'b0;
  endtask

  task automatic vs_pulse();
    vsync = 1'b1;
    tick(6);
    vsync = 1'b0;
    tick(6);
  endtask

  task automatic send_line(input int nbytes, input bit expect_px);
    logic [7:0] msb, b8;
    int         npix;
    exp_t       e;
    msb  = '0;
    npix = nbytes / 2;
    if (npix > int'(PPL)) npix = int'(PPL);
    href = 1'b1;
    for (int b = 0; b < nbytes; b++) begin
      b8 = (b == 0) ? 8'hA5 : (b == 1) ? 8'h3C : 8'($urandom_range(0, 255));
      din = b8;
      if (b % 2 == 0) msb = b8;
      else if (expect_px && (b / 2) < npix) begin
        e.pix = {msb, b8};
        e.sof = sof_exp;
        e.eol = ((b / 2) == npix - 1);
        e.cyc = cyc + 1 + L;
        sof_exp = 1'b0;
        q.push_back(e);
      end
      tick(1);
    end
    href = 1'b0;
    din  = '0;
    tick(8);
  endtask

  task automatic frame(input int nlines, input bit expect_px);
    vs_pulse();
    sof_exp = expect_px;
    repeat (nlines) send_line(8, expect_px);
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_pixel"}, 64'(pixel), 64'd0);
    chk({tag, "_pixel_valid"}, 64'(pixel_valid), 64'd0);
    chk({tag, "_sof"}, 64'(sof), 64'd0);
    chk({tag, "_eol"}, 64'(eol), 64'd0);
    chk({tag, "_busy"}, 64'(busy), 64'd0);
    chk({tag, "_hlen"}, 64'(hlen), 64'd0);
    chk({tag, "_vlen"}, 64'(vlen), 64'd0);
    chk({tag, "_frame_cnt"}, 64'(frame_cnt), 64'd0);
    chk({tag, "_line_err"}, 64'(line_err), 64'd0);
    chk({tag, "_frame_err"}, 64'(frame_err), 64'd0);
  endtask

  initial begin
    tick(3);
    check_zero("reset");
    rst = 1'b0;
    tick(2);

    // Unarmed: a whole frame passes without output.
    frame(NL, 1'b0);
    chk("idle_busy", 64'(busy), 64'd0);

    // Start mid-frame: rest of this frame is ignored.
    frame(1, 1'b0);
    pulse_start();
    chk("armed_busy", 64'(busy), 64'd1);
    send_line(8, 1'b0);
    send_line(8, 1'b0);

    frame(NL, 1'b1);
    chk("first_frame_cnt", 64'(frame_cnt), 64'd0);
    frame(NL, 1'b1);
    chk("frame_cnt_1", 64'(frame_cnt), 64'd1);
    chk("vlen_full", 64'(vlen), 64'(NL));
    chk("hlen_full", 64'(hlen), 64'(PPL));
    chk("no_line_err", 64'(line_err), 64'd0);

    // Glitches shorter than the filter must not create lines or end the frame.
    vs_pulse();
    sof_exp = 1'b1;
    send_line(8, 1'b1);
    href = 1'b1; tick(2); href = 1'b0; tick(6);
    send_line(8, 1'b1);
    vsync = 1'b1; tick(2); vsync = 1'b0; tick(6);
    send_line(8, 1'b1);

    vs_pulse();
    chk("glitch_frame_cnt", 64'(frame_cnt), 64'd3);
    chk("glitch_vlen", 64'(vlen), 64'(NL));
    chk("glitch_frame_err", 64'(frame_err), 64'd0);
    chk("glitch_line_err", 64'(line_err), 64'd0);

    // Odd-length line, then an over-long line capped at PPL, two lines total.
    sof_exp = 1'b1;
    send_line(7, 1'b1);
    chk("odd_hlen", 64'(hlen), 64'd3);
    chk("odd_line_err", 64'(line_err), 64'd1);
    send_line(10, 1'b1);
    chk("cap_hlen", 64'(hlen), 64'(PPL));
    chk("line_err_sticky", 64'(line_err), 64'd1);
    vs_pulse();
    chk("short_vlen", 64'(vlen), 64'd2);
    chk("short_frame_err", 64'(frame_err), 64'd1);
    chk("short_frame_cnt", 64'(frame_cnt), 64'd4);

    // Start while busy only clears errors; stop mid-frame finishes the frame.
    sof_exp = 1'b1;
    pulse_start();
    chk("clr_line_err", 64'(line_err), 64'd0);
    chk("clr_frame_err", 64'(frame_err), 64'd0);
    chk("busy_after_restart", 64'(busy), 64'd1);
    send_line(8, 1'b1);
    stop = 1'b1; tick(1); stop = 1'b0;
    send_line(8, 1'b1);
    send_line(8, 1'b1);
    chk("busy_before_end", 64'(busy), 64'd1);
    vs_pulse();
    chk("stopped_busy", 64'(busy), 64'd0);
    chk("stopped_vlen", 64'(vlen), 64'(NL));
    chk("stopped_frame_cnt", 64'(frame_cnt), 64'd5);

    frame(NL, 1'b0);
    chk("after_stop_busy", 64'(busy), 64'd0);
    chk("after_stop_frame_cnt", 64'(frame_cnt), 64'd5);

    start = 1'b1; stop = 1'b1; tick(1);
    start = 1'b0; stop = 1'b0; tick(3);
    chk("start_stop_busy", 64'(busy), 64'd0);
    chk("start_stop_frame_cnt", 64'(frame_cnt), 64'd5);

    // Re-arm, capture one line, then reset in the middle of the next.
    pulse_start();
    tick(1);
    chk("rearm_busy", 64'(busy), 64'd1);
    chk("rearm_frame_cnt", 64'(frame_cnt), 64'd0);
    vs_pulse();
    sof_exp = 1'b1;
    send_line(8, 1'b1);
    chk("pre_reset_hlen", 64'(hlen), 64'(PPL));
    href = 1'b1;
    for (int b = 0; b < 3; b++) begin
      din = 8'(b + 1);
      tick(1);
    end
    rst = 1'b1;
    tick(1);
    href = 1'b0;
    din  = '0;
    check_zero("midframe_reset");
    rst = 1'b0;
    tick(10);
    chk("post_reset_busy", 64'(busy), 64'd0);
    chk("queue_drained", 64'(q.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
